// File: rtl/if_id_queue_if.sv
// Fetch/decode side signals of the IF/ID instruction queue.
// slave = the queue, master = whoever drives fetch inputs and samples the head.
interface if_id_queue_if #(
   parameter int DEPTH = 2
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [31:0]   if_PC_in;
   logic [31:0]   if_NPC_in;
   logic [31:0]   if_IR_in;
   logic          if_valid_inst_in;
   logic          ex_take_branch_out;
   logic          id_stall;
   logic          if_stall;
   logic [31:0]   if_id_PC;
   logic [31:0]   if_id_NPC;
   logic [31:0]   if_id_IR;
   logic          if_id_valid_inst;
   logic [CW-1:0] if_id_count;

   modport slave (
      input  if_PC_in, if_NPC_in, if_IR_in, if_valid_inst_in,
      input  ex_take_branch_out, id_stall,
      output if_stall, if_id_PC, if_id_NPC, if_id_IR, if_id_valid_inst, if_id_count
   );

   modport master (
      output if_PC_in, if_NPC_in, if_IR_in, if_valid_inst_in,
      output ex_take_branch_out, id_stall,
      input  if_stall, if_id_PC, if_id_NPC, if_id_IR, if_id_valid_inst, if_id_count
   );
endinterface

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: DEPTH-entry FIFO of {PC, NPC, IR} bundles between
// fetch and decode. A taken branch from execute empties it in one cycle.
// Optional macro IF_ID_BYPASS_EN: an empty queue forwards the incoming bundle
// straight to the head outputs in the same cycle.
module if_id_queue #(
   parameter int          DEPTH    = 2,
   parameter logic [31:0] NOP_INST = 32'h47FF041F
) (
   input logic          clk,
   input logic          rst_n,
   if_id_queue_if.slave q
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] npc;
      logic [31:0] ir;
   } entry_t;

   entry_t        mem [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count;
   logic          full, empty, flush, push, pop, byp, byp_take;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign flush = q.ex_take_branch_out;

`ifdef IF_ID_BYPASS_EN
   // Bundle arriving at an empty queue goes straight to decode; it is only
   // stored if decode stalls this cycle.
   assign byp      = empty & ~flush & q.if_valid_inst_in;
   assign byp_take = byp & ~q.id_stall;
`else
   assign byp      = 1'b0;
   assign byp_take = 1'b0;
`endif

   assign push = q.if_valid_inst_in & ~full & ~flush & ~byp_take;
   assign pop  = ~empty & ~q.id_stall & ~flush;

   // Pointer and occupancy update; flush beats every other event.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry storage; contents need no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= '{pc: q.if_PC_in, npc: q.if_NPC_in, ir: q.if_IR_in};
   end

   // Head presentation: stored entry, else bypassed input, else a NOP bubble.
   always_comb begin
      q.if_id_valid_inst = 1'b0;
      q.if_id_IR         = NOP_INST;
      q.if_id_PC         = '0;
      q.if_id_NPC        = '0;
      if (!empty) begin
         q.if_id_valid_inst = 1'b1;
         q.if_id_IR         = mem[rd_ptr].ir;
         q.if_id_PC         = mem[rd_ptr].pc;
         q.if_id_NPC        = mem[rd_ptr].npc;
      end else if (byp) begin
         q.if_id_valid_inst = 1'b1;
         q.if_id_IR         = q.if_IR_in;
         q.if_id_PC         = q.if_PC_in;
         q.if_id_NPC        = q.if_NPC_in;
      end
      if (flush) begin
         q.if_id_valid_inst = 1'b0;
         q.if_id_IR         = NOP_INST;
      end
   end

   // Stall is purely registered state so decode's stall never loops into fetch.
   assign q.if_stall    = full;
   assign q.if_id_count = count;

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: the driver appends accepted bundles to a
// model queue, a negedge monitor compares the head/count/stall and retires
// entries as decode consumes them.
module tb_if_id_queue;
   localparam int          DEPTH = 2;
   localparam logic [31:0] NOP   = 32'h47FF041F;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   if_id_queue_if #(.DEPTH(DEPTH)) bus ();

   if_id_queue #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .q     (bus)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] npc;
      logic [31:0] ir;
   } bundle_t;

   bundle_t mq[$];
   bit      cyc_push = 0;
   bit      started = 0;
   int      checks = 0;
   int      failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle of fetch/execute/decode stimulus; records accepted bundles.
   task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] ir,
                        input bit br, input bit st);
      @(posedge clk);
      #1;
      bus.if_valid_inst_in   = v;
      bus.if_PC_in           = pc;
      bus.if_NPC_in          = pc + 32'd4;
      bus.if_IR_in           = ir;
      bus.ex_take_branch_out = br;
      bus.id_stall           = st;
      cyc_push = v && !br && (mq.size() < DEPTH);
      if (cyc_push) mq.push_back('{pc: pc, npc: pc + 32'd4, ir: ir});
   endtask

   // Monitor: mq minus this cycle's append is the occupancy the queue holds.
   int rc;
   bit byp;
   always @(negedge clk) begin
      if (rst_n && started) begin
         rc = mq.size() - (cyc_push ? 1 : 0);
         chk("count", 32'(bus.if_id_count), rc);
         chk("if_stall", 32'(bus.if_stall), 32'(rc == DEPTH));
         byp = 0;
`ifdef IF_ID_BYPASS_EN
         byp = (rc == 0) && cyc_push;
`endif
         if (bus.ex_take_branch_out) begin
            chk("flush_valid", 32'(bus.if_id_valid_inst), 0);
            chk("flush_ir", bus.if_id_IR, NOP);
            mq.delete();
         end else if (rc > 0 || byp) begin
            chk("head_valid", 32'(bus.if_id_valid_inst), 1);
            chk("head_pc", bus.if_id_PC, mq[0].pc);
            chk("head_npc", bus.if_id_NPC, mq[0].npc);
            chk("head_ir", bus.if_id_IR, mq[0].ir);
            if (!bus.id_stall) void'(mq.pop_front());
         end else begin
            chk("empty_valid", 32'(bus.if_id_valid_inst), 0);
            chk("empty_ir", bus.if_id_IR, NOP);
            chk("empty_pc", bus.if_id_PC, 0);
            chk("empty_npc", bus.if_id_NPC, 0);
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_count"}, 32'(bus.if_id_count), 0);
      chk({tag, "_stall"}, 32'(bus.if_stall), 0);
      chk({tag, "_ir"}, bus.if_id_IR, NOP);
      chk({tag, "_valid"}, 32'(bus.if_id_valid_inst), 0);
      chk({tag, "_pc"}, bus.if_id_PC, 0);
      chk({tag, "_npc"}, bus.if_id_NPC, 0);
   endtask

   initial begin
      bus.if_valid_inst_in   = 0;
      bus.if_PC_in           = '0;
      bus.if_NPC_in          = '0;
      bus.if_IR_in           = '0;
      bus.ex_take_branch_out = 0;
      bus.id_stall           = 0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1;
      started = 1;
      drive(0, 0, 0, 0, 0);

      // Streaming with decode always ready
      for (int i = 0; i < 4; i++) drive(1, 32'(i * 4), $urandom, 0, 0);
      drive(0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0);

      // Fill to full with decode stalled, then re-present the refused bundle
      drive(1, 32'h10, $urandom, 0, 1);
      drive(1, 32'h14, $urandom, 0, 1);
      drive(1, 32'h18, 32'hAAAA0018, 0, 1);
      drive(1, 32'h18, 32'hAAAA0018, 0, 0);
      drive(1, 32'h18, 32'hAAAA0018, 0, 0);
      repeat (3) drive(0, 0, 0, 0, 0);

      // Flush with two entries and a wrong-path bundle, then branch target
      drive(1, 32'h20, $urandom, 0, 1);
      drive(1, 32'h24, $urandom, 0, 1);
      drive(1, 32'h40, $urandom, 1, 1);
      drive(1, 32'h100, 32'h0B0B0100, 0, 0);
      repeat (2) drive(0, 0, 0, 0, 0);

      // Pointer wrap: one entry parked, then nine push/pop pairs
      drive(1, 32'h200, $urandom, 0, 1);
      for (int i = 1; i <= 9; i++) drive(1, 32'h200 + 32'(i * 4), $urandom, 0, 0);
      repeat (2) drive(0, 0, 0, 0, 0);

      // Empty queue, decode ready: same cycle in bypass build, next cycle otherwise
      drive(1, 32'h300, 32'hDEADBEEF, 0, 0);
      repeat (2) drive(0, 0, 0, 0, 0);

      // Random traffic
      for (int i = 0; i < 400; i++)
         drive($urandom_range(0, 3) != 0, 32'($urandom_range(0, 1023)) << 2, $urandom,
               $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 4);

      // Asynchronous reset with two entries held
      drive(1, 32'h500, $urandom, 0, 1);
      drive(1, 32'h504, $urandom, 0, 1);
      drive(0, 0, 0, 0, 1);
      #1;
      rst_n = 0;
      #1;
      check_reset_outputs("async_rst");
      mq.delete();
      cyc_push = 0;
      @(posedge clk);
      #1;
      bus.id_stall = 0;
      rst_n = 1;
      drive(1, 32'h600, $urandom, 0, 0);
      repeat (3) drive(0, 0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
